pe_config_sequencer: RTL and testbench

//  Drives the pex_config word of every PE in an array. Config words arrive over a

---
 rtl/pe_config_sequencer_pkg.sv | 32 +++
 rtl/pe_config_sequencer_ctx_mem.sv | 51 +++++
 rtl/pe_config_sequencer.sv | 151 +++++++++++++++
 tb/tb_pe_config_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_config_sequencer_pkg.sv
// Shared constants, config-word field layout and FSM encoding for pe_config_sequencer.
// No logic; imported by the sequencer top and its context memory.
package pe_config_sequencer_pkg;

  localparam int CFG_WORD_W = 7;

  localparam int OP_MSB  = 6;
  localparam int OP_LSB  = 4;
  localparam int RHS_MSB = 3;
  localparam int RHS_LSB = 2;
  localparam int LHS_MSB = 1;
  localparam int LHS_LSB = 0;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]   op;
    logic [RHS_MSB-RHS_LSB:0] rhs;
    logic [LHS_MSB-LHS_LSB:0] lhs;
  } cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index width for an n-entry table; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_config_sequencer_ctx_mem.sv
// Per-PE, per-context config register file: one write port, NUM_PE parallel reads of one context.
// Read is combinational from the stored flops; write lands on the next clock edge.
module pe_config_sequencer_ctx_mem
  import pe_config_sequencer_pkg::*;
#(
  parameter int NUM_PE  = 4,
  parameter int NUM_CTX = 8,
  parameter int CFG_W   = CFG_WORD_W,
  parameter int PE_W    = idx_w(NUM_PE),
  parameter int CTX_W   = idx_w(NUM_CTX)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [PE_W-1:0]         wr_pe,
  input  logic [CTX_W-1:0]        wr_ctx,
  input  logic [CFG_W-1:0]        wr_dat,
  input  logic [CTX_W-1:0]        rd_ctx,
  output logic [NUM_PE*CFG_W-1:0] rd_dat
);

  logic [CFG_W-1:0] mem_q [NUM_PE][NUM_CTX];
  logic [CFG_W-1:0] mem_d [NUM_PE][NUM_CTX];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_pe][wr_ctx] = wr_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PE; p++) begin
        for (int c = 0; c < NUM_CTX; c++) begin
          mem_q[p][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      rd_dat[p*CFG_W +: CFG_W] = mem_q[p][rd_ctx];
    end
  end

endmodule

// File: rtl/pe_config_sequencer.sv
// Loads per-PE context words, then clears the PE accumulators and replays contexts 0..run_last
// for the requested number of iterations; all outputs except cfg_ready are registered.
module pe_config_sequencer
  import pe_config_sequencer_pkg::*;
#(
  parameter int NUM_PE  = 4,
  parameter int NUM_CTX = 8,
  parameter int CFG_W   = CFG_WORD_W,
  parameter int PE_W    = idx_w(NUM_PE),
  parameter int CTX_W   = idx_w(NUM_CTX)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PE_W-1:0]         cfg_pe,
  input  logic [CTX_W-1:0]        cfg_ctx,
  input  logic [CFG_W-1:0]        cfg_word,
  input  logic                    start,
  input  logic [CTX_W-1:0]        run_last,
  input  logic [7:0]              iterations,
  input  logic                    abort,
  output logic [NUM_PE*CFG_W-1:0] pex_config,
  output logic                    pe_clear,
  output logic                    busy,
  output logic                    done
);

  state_t                    state_q, state_d;
  logic [CTX_W-1:0]          ctx_q, ctx_d;
  logic [CTX_W-1:0]          run_last_q, run_last_d;
  logic [7:0]                iter_q, iter_d;
  logic [7:0]                iter_last_q, iter_last_d;
  logic [NUM_PE*CFG_W-1:0]   pex_config_q, pex_config_d;
  logic                      pe_clear_q, pe_clear_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      wr_en;
  logic [NUM_PE*CFG_W-1:0]   rd_dat;

  assign cfg_ready = (state_q == ST_IDLE);
  // Out-of-range targets still handshake; the word is simply not stored.
  assign wr_en = cfg_valid && cfg_ready
                 && (int'(cfg_pe) < NUM_PE) && (int'(cfg_ctx) < NUM_CTX);

  pe_config_sequencer_ctx_mem #(
    .NUM_PE  (NUM_PE),
    .NUM_CTX (NUM_CTX),
    .CFG_W   (CFG_W),
    .PE_W    (PE_W),
    .CTX_W   (CTX_W)
  ) u_ctx_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_pe   (cfg_pe),
    .wr_ctx  (cfg_ctx),
    .wr_dat  (cfg_word),
    .rd_ctx  (ctx_d),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    state_d      = state_q;
    ctx_d        = ctx_q;
    iter_d       = iter_q;
    run_last_d   = run_last_q;
    iter_last_d  = iter_last_q;
    pex_config_d = pex_config_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          run_last_d  = run_last;
          iter_last_d = (iterations == 8'd0) ? 8'd0 : iterations - 8'd1;
          ctx_d       = '0;
          iter_d      = '0;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d      = ST_IDLE;
          pex_config_d = '0;
        end else begin
          state_d      = ST_RUN;
          ctx_d        = '0;
          iter_d       = '0;
          pex_config_d = rd_dat;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d      = ST_IDLE;
          pex_config_d = '0;
        end else if (ctx_q == run_last_q) begin
          if (iter_q == iter_last_q) begin
            // Final context stays on the bus through DONE and beyond.
            state_d = ST_DONE;
          end else begin
            ctx_d        = '0;
            iter_d       = iter_q + 8'd1;
            pex_config_d = rd_dat;
          end
        end else begin
          ctx_d        = ctx_q + CTX_W'(1);
          pex_config_d = rd_dat;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pe_clear_d = (state_d == ST_CLEAR);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ctx_q        <= '0;
      iter_q       <= '0;
      run_last_q   <= '0;
      iter_last_q  <= '0;
      pex_config_q <= '0;
      pe_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctx_q        <= ctx_d;
      iter_q       <= iter_d;
      run_last_q   <= run_last_d;
      iter_last_q  <= iter_last_d;
      pex_config_q <= pex_config_d;
      pe_clear_q   <= pe_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pex_config = pex_config_q;
  assign pe_clear   = pe_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pe_config_sequencer.sv
// Directed bench for pe_config_sequencer: a per-cycle vector table for load/run basics,
// then hand-written sequences for multi-iteration runs, blocked loads, abort and mid-run reset.
module tb_pe_config_sequencer;

  localparam int NP = 4;
  localparam int NC = 8;
  localparam int W  = 7;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [1:0]      cfg_pe = '0;
  logic [2:0]      cfg_ctx = '0;
  logic [W-1:0]    cfg_word = '0;
  logic            start = 1'b0;
  logic [2:0]      run_last = '0;
  logic [7:0]      iterations = '0;
  logic            abort = 1'b0;
  logic [NP*W-1:0] pex_config;
  logic            pe_clear;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_mem [NP][NC];

  always #5 clk = ~clk;

  pe_config_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pe     (cfg_pe),
    .cfg_ctx    (cfg_ctx),
    .cfg_word   (cfg_word),
    .start      (start),
    .run_last   (run_last),
    .iterations (iterations),
    .abort      (abort),
    .pex_config (pex_config),
    .pe_clear   (pe_clear),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string           nm;
    logic            v;
    logic [1:0]      pe;
    logic [2:0]      ctx;
    logic [W-1:0]    w;
    logic            st;
    logic [2:0]      rl;
    logic [7:0]      it;
    logic [NP*W-1:0] e_pex;
    logic            e_clr;
    logic            e_busy;
    logic            e_done;
    logic            e_rdy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    cfg_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  function automatic logic [NP*W-1:0] exp_pex(input int c);
    logic [NP*W-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) r[p*W +: W] = exp_mem[p][c];
    return r;
  endfunction

  task automatic load(input int pe, input int c, input logic [W-1:0] w);
    cfg_valid = 1'b1;
    cfg_pe    = 2'(pe);
    cfg_ctx   = 3'(c);
    cfg_word  = w;
    chk("load_rdy", {31'd0, cfg_ready}, 32'd1);
    tick;
    cfg_valid = 1'b0;
    exp_mem[pe][c] = w;
  endtask

  task automatic begin_run(input logic [2:0] rl, input logic [7:0] it);
    start      = 1'b1;
    run_last   = rl;
    iterations = it;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  task automatic clear_model;
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < NC; c++) exp_mem[p][c] = '0;
  endtask

  initial begin
    int ndone;
    int nbusy;

    clear_model();

    // 1: reset values
    #2 reset_n = 1'b0;
    #10;
    chk("rst_pex", 32'(pex_config), 32'd0);
    chk("rst_clr", {31'd0, pe_clear}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick;
    chk("post_rst_rdy", {31'd0, cfg_ready}, 32'd1);

    // 2, 4 and start+load in the same cycle as per-cycle vectors
    tbl[0]  = '{"ld_pe0c0",  1, 0, 0, 7'h15, 0, 0, 0, 28'h0000000, 0, 0, 0, 1};
    tbl[1]  = '{"ld_pe1c1",  1, 1, 1, 7'h2A, 0, 0, 0, 28'h0000000, 0, 0, 0, 1};
    tbl[2]  = '{"r1_clear",  0, 0, 0, 7'h00, 1, 1, 1, 28'h0000000, 1, 1, 0, 0};
    tbl[3]  = '{"r1_run0",   0, 0, 0, 7'h00, 0, 0, 0, 28'h0000015, 0, 1, 0, 0};
    tbl[4]  = '{"r1_run1",   0, 0, 0, 7'h00, 0, 0, 0, 28'h0001500, 0, 1, 0, 0};
    tbl[5]  = '{"r1_done",   0, 0, 0, 7'h00, 0, 0, 0, 28'h0001500, 0, 1, 1, 0};
    tbl[6]  = '{"r1_idle",   0, 0, 0, 7'h00, 0, 0, 0, 28'h0001500, 0, 0, 0, 1};
    tbl[7]  = '{"it0_clear", 0, 0, 0, 7'h00, 1, 0, 0, 28'h0001500, 1, 1, 0, 0};
    tbl[8]  = '{"it0_run0",  0, 0, 0, 7'h00, 0, 0, 0, 28'h0000015, 0, 1, 0, 0};
    tbl[9]  = '{"it0_done",  0, 0, 0, 7'h00, 0, 0, 0, 28'h0000015, 0, 1, 1, 0};
    tbl[10] = '{"it0_idle",  0, 0, 0, 7'h00, 0, 0, 0, 28'h0000015, 0, 0, 0, 1};
    tbl[11] = '{"sl_clear",  1, 2, 0, 7'h33, 1, 0, 1, 28'h0000015, 1, 1, 0, 0};
    tbl[12] = '{"sl_run0",   0, 0, 0, 7'h00, 0, 0, 0, 28'h00CC015, 0, 1, 0, 0};
    tbl[13] = '{"sl_done",   0, 0, 0, 7'h00, 0, 0, 0, 28'h00CC015, 0, 1, 1, 0};
    tbl[14] = '{"sl_idle",   0, 0, 0, 7'h00, 0, 0, 0, 28'h00CC015, 0, 0, 0, 1};

    for (int i = 0; i < 15; i++) begin
      cfg_valid  = tbl[i].v;
      cfg_pe     = tbl[i].pe;
      cfg_ctx    = tbl[i].ctx;
      cfg_word   = tbl[i].w;
      start      = tbl[i].st;
      run_last   = tbl[i].rl;
      iterations = tbl[i].it;
      abort      = 1'b0;
      tick;
      chk({tbl[i].nm, "_pex"}, 32'(pex_config), 32'(tbl[i].e_pex));
      chk({tbl[i].nm, "_clr"}, {31'd0, pe_clear}, {31'd0, tbl[i].e_clr});
      chk({tbl[i].nm, "_busy"}, {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk({tbl[i].nm, "_done"}, {31'd0, done}, {31'd0, tbl[i].e_done});
      chk({tbl[i].nm, "_rdy"}, {31'd0, cfg_ready}, {31'd0, tbl[i].e_rdy});
    end
    idle_in();
    exp_mem[0][0] = 7'h15;
    exp_mem[1][1] = 7'h2A;
    exp_mem[2][0] = 7'h33;

    // 3: run_last=2, iterations=3 -> contexts 0,1,2 repeated three times
    load(3, 0, 7'h01);
    load(3, 1, 7'h02);
    load(3, 2, 7'h03);
    load(1, 2, 7'h44);
    begin_run(3'd2, 8'd3);
    chk("m3_clear", {31'd0, pe_clear}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 9; k++) begin
      tick;
      chk($sformatf("m3_run%0d", k), 32'(pex_config), 32'(exp_pex(k % 3)));
      if (done) ndone++;
    end
    tick;
    chk("m3_done", {31'd0, done}, 32'd1);
    if (done) ndone++;
    tick;
    if (done) ndone++;
    chk("m3_done_count", 32'(ndone), 32'd1);
    chk("m3_idle_busy", {31'd0, busy}, 32'd0);

    // 5: load attempt and start pulse during RUN are both ignored
    begin_run(3'd2, 8'd2);
    tick;
    tick;
    cfg_valid = 1'b1; cfg_pe = 2'd0; cfg_ctx = 3'd0; cfg_word = 7'h7F;
    start = 1'b1; run_last = 3'd0; iterations = 8'd1;
    #1;
    chk("m5_rdy_run", {31'd0, cfg_ready}, 32'd0);
    tick;
    chk("m5_rdy_run2", {31'd0, cfg_ready}, 32'd0);
    idle_in();
    wait_done("m5_done");
    nbusy = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (busy) nbusy++;
    end
    chk("m5_no_rerun", 32'(nbusy), 32'd0);
    begin_run(3'd0, 8'd1);
    tick;
    chk("m5_mem_kept", 32'(pex_config), 32'(exp_pex(0)));
    wait_done("m5_done2");
    tick;

    // 6a: abort in the second RUN cycle
    begin_run(3'd2, 8'd1);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_pex", 32'(pex_config), 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_rdy", {31'd0, cfg_ready}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (done) ndone++;
    end
    chk("ab_no_done", 32'(ndone), 32'd0);

    // 6b: reset mid-run wipes outputs and context storage
    begin_run(3'd2, 8'd1);
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk("mr_pex", 32'(pex_config), 32'd0);
    chk("mr_clr", {31'd0, pe_clear}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_rdy", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_model();
    begin_run(3'd2, 8'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("mr_rerun%0d", k), 32'(pex_config), 32'(exp_pex(k)));
    end
    wait_done("mr_done_end");
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
